lcd_text_scanner: RTL and testbench

// Scans the LCD active area and requests one character per 8x8 cell via column/row.
// The requests go to the combinational text-content source (the debug-screen generator).

---
 rtl/lcd_text_scanner_if.sv | 26 ++
 rtl/lcd_text_scanner.sv | 158 +++++++++++++++
 tb/tb_lcd_text_scanner.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_scanner_if.sv
// rtl/lcd_text_scanner_if.sv - character lookup and font ROM link between scanner and content/ROM side
interface lcd_text_scanner_if;
  logic [6:0] column;
  logic [5:0] row;
  logic [6:0] character;
  logic [9:0] font_address;
  logic [7:0] font_data;

  // Scanner side: publishes the cell position and ROM address, consumes character and glyph line
  modport master (
    output column,
    output row,
    output font_address,
    input  character,
    input  font_data
  );

  // Text source / font ROM side
  modport slave (
    input  column,
    input  row,
    input  font_address,
    output character,
    output font_data
  );
endinterface

// File: rtl/lcd_text_scanner.sv
// rtl/lcd_text_scanner.sv - 8x8 character-cell text renderer with 3-cycle aligned sync/enable pipeline
module lcd_text_scanner #(
  parameter int          H_ACTIVE     = 800,
  parameter int          V_ACTIVE     = 480,
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter logic        HSYNC_ACTIVE = 1'b0,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_de,
  input  logic               in_hsync,
  input  logic               in_vsync,
  lcd_text_scanner_if.master txt,
  output logic               out_de,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic [23:0]        out_rgb
);

  localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] LP_CNT_MAX  = 10'h3FF;

  // Pixel/line counters
  logic [9:0] r_x;
  logic [9:0] r_y;

  // Stage 1: address presented to the ROM plus side-band for the same pixel
  logic [9:0] r_font_address;
  logic [2:0] r_s1_xlo;
  logic       r_s1_inr;
  logic       r_s1_de;
  logic       r_s1_hs;
  logic       r_s1_vs;

  // Stage 2: side-band aligned with font_data coming back from the ROM
  logic [2:0] r_s2_xlo;
  logic       r_s2_inr;
  logic       r_s2_de;
  logic       r_s2_hs;
  logic       r_s2_vs;

  // Stage 3: registered outputs
  logic [23:0] r_rgb;
  logic        r_de;
  logic        r_hs;
  logic        r_vs;

  logic       w_de_fall;
  logic       w_vs_active;
  logic       w_in_range;
  logic [2:0] w_bit_idx;
  logic       w_glyph_bit;
  logic       w_pix_on;

  // r_s1_de doubles as the one-cycle-delayed enable used for line-end detection
  assign w_de_fall   = r_s1_de & ~in_de;
  assign w_vs_active = (in_vsync == VSYNC_ACTIVE);
  assign w_in_range  = (r_x < LP_H_ACTIVE) && (r_y < LP_V_ACTIVE);

  // Bit 7 of the glyph line is the leftmost pixel of the cell
  assign w_bit_idx   = 3'd7 - r_s2_xlo;
  assign w_glyph_bit = txt.font_data[w_bit_idx];
  assign w_pix_on    = w_glyph_bit & r_s2_inr;

  assign txt.column       = r_x[9:3];
  assign txt.row          = r_y[8:3];
  assign txt.font_address = r_font_address;

  assign out_de    = r_de;
  assign out_hsync = r_hs;
  assign out_vsync = r_vs;
  assign out_rgb   = r_rgb;

  // Horizontal pixel counter: runs while enable is high, saturates, restarts at 0 when idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
    end else if (in_de) begin
      if (r_x != LP_CNT_MAX) begin
        r_x <= r_x + 10'd1;
      end
    end else begin
      r_x <= '0;
    end
  end

  // Line counter: advances on each enable falling edge; vsync forces it to 0 and has priority
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_y <= '0;
    end else if (w_vs_active) begin
      r_y <= '0;
    end else if (w_de_fall && (r_y != LP_CNT_MAX)) begin
      r_y <= r_y + 10'd1;
    end
  end

  // Stage 1: capture ROM address from the live character and the pixel's side-band
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_font_address <= '0;
      r_s1_xlo       <= '0;
      r_s1_inr       <= 1'b0;
      r_s1_de        <= 1'b0;
      r_s1_hs        <= ~HSYNC_ACTIVE;
      r_s1_vs        <= ~VSYNC_ACTIVE;
    end else begin
      r_font_address <= {txt.character, r_y[2:0]};
      r_s1_xlo       <= r_x[2:0];
      r_s1_inr       <= w_in_range;
      r_s1_de        <= in_de;
      r_s1_hs        <= in_hsync;
      r_s1_vs        <= in_vsync;
    end
  end

  // Stage 2: hold side-band for the ROM's one-cycle read latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_xlo <= '0;
      r_s2_inr <= 1'b0;
      r_s2_de  <= 1'b0;
      r_s2_hs  <= ~HSYNC_ACTIVE;
      r_s2_vs  <= ~VSYNC_ACTIVE;
    end else begin
      r_s2_xlo <= r_s1_xlo;
      r_s2_inr <= r_s1_inr;
      r_s2_de  <= r_s1_de;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
    end
  end

  // Stage 3: colour the pixel; blanked cycles drive black regardless of glyph content
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb <= '0;
      r_de  <= 1'b0;
      r_hs  <= ~HSYNC_ACTIVE;
      r_vs  <= ~VSYNC_ACTIVE;
    end else begin
      if (!r_s2_de) begin
        r_rgb <= '0;
      end else if (w_pix_on) begin
        r_rgb <= FG_COLOR;
      end else begin
        r_rgb <= BG_COLOR;
      end
      r_de <= r_s2_de;
      r_hs <= r_s2_hs;
      r_vs <= r_s2_vs;
    end
  end

endmodule

// File: tb/tb_lcd_text_scanner.sv
// tb/tb_lcd_text_scanner.sv - directed and table-driven checks for lcd_text_scanner
module tb_lcd_text_scanner;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_de = 1'b0;
  logic        in_hsync = 1'b1;
  logic        in_vsync = 1'b1;
  logic        out_de;
  logic        out_hsync;
  logic        out_vsync;
  logic [23:0] out_rgb;

  int checks = 0;
  int errors = 0;
  int char_mode = 0;
  int rom_mode = 0;

  lcd_text_scanner_if txt ();

  lcd_text_scanner dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_de     (in_de),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .txt       (txt.master),
    .out_de    (out_de),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_rgb   (out_rgb)
  );

  always #5 clock = ~clock;

  // Combinational text source: fixed 'A' or a code derived from the cell position
  logic [6:0] w_char_calc;
  assign w_char_calc = txt.column + {txt.row[2:0], 4'b0000};
  always_comb begin
    txt.character = 7'h41;
    if (char_mode == 1) txt.character = w_char_calc;
  end

  // Synchronous font ROM model
  always @(posedge clock) begin
    if (rom_mode == 1) txt.font_data <= (txt.font_address == 10'h10D) ? 8'h04 : 8'h00;
    else               txt.font_data <= 8'h81;
  end

  typedef struct {
    logic        de;
    logic        hs;
    logic        e_de;
    logic        e_hs;
    logic [23:0] e_rgb;
    logic        chk_fa;
    logic [9:0]  e_fa;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic de, logic hs, logic e_de, logic e_hs,
                              logic [23:0] e_rgb, logic chk_fa, logic [9:0] e_fa);
    vec_t v;
    v.de = de; v.hs = hs; v.e_de = e_de; v.e_hs = e_hs;
    v.e_rgb = e_rgb; v.chk_fa = chk_fa; v.e_fa = e_fa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic de, input logic hs, input logic vs);
    in_de = de;
    in_hsync = hs;
    in_vsync = vs;
    @(posedge clock);
    #1;
  endtask

  task automatic vsync_pulse();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic line(input int len, input int idle);
    for (int i = 0; i < len; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < idle; i++) step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      in_de = 1'($urandom); in_hsync = 1'($urandom); in_vsync = 1'($urandom);
      @(posedge clock);
      #1;
    end
    chk("rst_out_de", 32'(out_de), 0);
    chk("rst_out_rgb", 32'(out_rgb), 0);
    chk("rst_out_hsync", 32'(out_hsync), 1);
    chk("rst_out_vsync", 32'(out_vsync), 1);
    chk("rst_column", 32'(txt.column), 0);
    chk("rst_row", 32'(txt.row), 0);
    in_de = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1;
    reset_n = 1'b1;

    // Latency table: 'A', ROM line 1000_0001, outputs lag inputs by two steps here
    vecs[0]  = mk(0, 1, 0, 1, 24'h0, 0, 10'h0);
    vecs[1]  = mk(0, 0, 0, 1, 24'h0, 0, 10'h0);
    vecs[2]  = mk(1, 1, 0, 1, 24'h0, 1, 10'h208);
    vecs[3]  = mk(1, 1, 0, 0, 24'h0, 0, 10'h0);
    vecs[4]  = mk(1, 1, 1, 1, 24'hFFFFFF, 0, 10'h0);
    vecs[5]  = mk(1, 1, 1, 1, 24'h000000, 0, 10'h0);
    vecs[6]  = mk(1, 1, 1, 1, 24'h000000, 0, 10'h0);
    vecs[7]  = mk(1, 1, 1, 1, 24'h000000, 0, 10'h0);
    vecs[8]  = mk(1, 1, 1, 1, 24'h000000, 0, 10'h0);
    vecs[9]  = mk(1, 1, 1, 1, 24'h000000, 0, 10'h0);
    vecs[10] = mk(0, 1, 1, 1, 24'h000000, 0, 10'h0);
    vecs[11] = mk(0, 1, 1, 1, 24'hFFFFFF, 0, 10'h0);
    vecs[12] = mk(0, 1, 0, 1, 24'h000000, 0, 10'h0);
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].de, vecs[i].hs, 1'b1);
      chk($sformatf("lat_de[%0d]", i), 32'(out_de), 32'(vecs[i].e_de));
      chk($sformatf("lat_hs[%0d]", i), 32'(out_hsync), 32'(vecs[i].e_hs));
      chk($sformatf("lat_vs[%0d]", i), 32'(out_vsync), 1);
      chk($sformatf("lat_rgb[%0d]", i), 32'(out_rgb), 32'(vecs[i].e_rgb));
      if (vecs[i].chk_fa) chk($sformatf("lat_fa[%0d]", i), 32'(txt.font_address), 32'(vecs[i].e_fa));
    end

    // Mapping: 21 lines, then pixel 13 of line 21
    vsync_pulse();
    char_mode = 1; rom_mode = 1;
    for (int l = 0; l < 21; l++) line(16, 2);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (i == 12) begin
        chk("map_column", 32'(txt.column), 1);
        chk("map_row", 32'(txt.row), 2);
      end
      if (i == 13) chk("map_fa", 32'(txt.font_address), 32'h10D);
      if (i == 14) chk("map_px12", 32'(out_rgb), 0);
      if (i == 15) chk("map_px13", 32'(out_rgb), 32'hFFFFFF);
    end
    step(1'b0, 1'b1, 1'b1);
    chk("map_px14", 32'(out_rgb), 0);
    step(1'b0, 1'b1, 1'b1);
    char_mode = 0; rom_mode = 0;

    // Vsync realignment and propagation
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("vs_out_pre", 32'(out_vsync), 1);
    step(1'b0, 1'b1, 1'b1);
    chk("vs_out_active", 32'(out_vsync), 0);
    for (int l = 0; l < 10; l++) line(8, 2);
    chk("vs_row_before", 32'(txt.row), 1);
    vsync_pulse();
    chk("vs_row_after", 32'(txt.row), 0);
    step(1'b1, 1'b1, 1'b1);
    chk("vs_fa_after", 32'(txt.font_address), 32'h208);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    // de fall coincident with vsync: y must be 0, not 1
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("vs_coincident_fa", 32'(txt.font_address), 32'h208);
    // de falls then rises in consecutive cycles: x restarts, y+1 once
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("fallrise_fa", 32'(txt.font_address), 32'h209);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("fallrise_de", 32'(out_de), 1);
    chk("fallrise_x0_rgb", 32'(out_rgb), 32'hFFFFFF);
    line(0, 3);

    // One-cycle de pulses, then the line below the active area
    vsync_pulse();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("pulse_de", 32'(out_de), 1);
    chk("pulse_rgb", 32'(out_rgb), 32'hFFFFFF);
    for (int l = 0; l < 479; l++) line(1, 1);
    chk("bottom_row", 32'(txt.row), 60);
    for (int i = 0; i < 10; i++) begin
      step(i < 8, 1'b1, 1'b1);
      if (i >= 2) begin
        chk($sformatf("bottom_de[%0d]", i - 2), 32'(out_de), 1);
        chk($sformatf("bottom_rgb[%0d]", i - 2), 32'(out_rgb), 0);
      end
    end
    line(0, 2);

    // Right edge: de held 810 cycles
    vsync_pulse();
    for (int i = 0; i < 812; i++) begin
      step(i < 810, 1'b1, 1'b1);
      if (i >= 794) begin
        int p;
        logic [23:0] e;
        p = i - 2;
        e = (p < 800 && ((p % 8) == 0 || (p % 8) == 7)) ? 24'hFFFFFF : 24'h000000;
        chk($sformatf("edge_de[%0d]", p), 32'(out_de), 1);
        chk($sformatf("edge_rgb[%0d]", p), 32'(out_rgb), 32'(e));
      end
    end
    line(0, 3);

    // Mid-line reset at x=200 on line 3
    vsync_pulse();
    for (int l = 0; l < 3; l++) line(8, 2);
    line(200, 0);
    chk("mid_pre_de", 32'(out_de), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_de", 32'(out_de), 0);
    chk("mid_rst_rgb", 32'(out_rgb), 0);
    chk("mid_rst_hs", 32'(out_hsync), 1);
    chk("mid_rst_vs", 32'(out_vsync), 1);
    chk("mid_rst_column", 32'(txt.column), 0);
    chk("mid_rst_row", 32'(txt.row), 0);
    chk("mid_rst_fa", 32'(txt.font_address), 0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    chk("mid_rel_fa", 32'(txt.font_address), 32'h208);
    chk("mid_rel_row", 32'(txt.row), 0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("mid_rel_de", 32'(out_de), 1);
    chk("mid_rel_rgb", 32'(out_rgb), 32'hFFFFFF);
    line(0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
